instr_pipeline: RTL and testbench
=================================

INSTR_PIPELINE -- requirements
Module: instr_pipeline

Interface
- REQ-001 The block SHALL have one parameter: NOP_WORD, default 32'h0000_0000, meaning the instruction word inserted as a bubble.
- REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003 reset  input  1  reset; SHALL be asynchronous and active-high.
- REQ-004 instr_f  input  32  instruction fetched this cycle.
- REQ-005 pc_f  input  32  address of instr_f.
- REQ-006 flush_d  input  1  branch/jump resolved in D; when high, the F word SHALL NOT be captured and NOP_WORD SHALL load IF/ID instead.
- REQ-007 instr_d, instr_e, instr_m, instr_w  output  32 each  instruction words for the D, E, M and W stages; these feed the per-stage decoders.
- REQ-008 pc8_d, pc8_e, pc8_m, pc8_w  output  32 each  PC+8 of the instruction held in each stage.
- REQ-009 stall  output  1  combinational; high SHALL freeze the PC register and IF/ID.
- REQ-010 stall_cnt  output  16  count of stall cycles since reset.

Function
- REQ-011 Decode rules: op = [31:26], func = [5:0], rs = [25:21], rt = [20:16], rd = [15:11]. Supported instructions: addu (000000/100001), subu (000000/100011), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, jr (000000/001000). Any other word SHALL be treated as reading nothing and writing nothing.
- REQ-012 Destination register: addu/subu -> rd; ori/lw/lui -> rt; jal -> 5'd31; all others -> 0. A destination of 0 SHALL never cause a stall.
- REQ-013 Tuse in D: beq rs,rt = 0; jr rs = 0; addu/subu rs,rt = 1; ori/lw/sw rs = 1; sw rt = 2; unused source = infinite (never stalls).
- REQ-014 Tnew on entry to E: lw = 2; addu/subu/ori/lui = 1; jal = 0. A 2-bit tnew field SHALL travel with each instruction and decrement, saturating at 0, on every advance E->M->W.
- REQ-015 stall SHALL be 1 when, for src in {rs, rt} used by instr_d: src != 0, src == dst_e and tuse < tnew_e; or src == dst_m and tuse < tnew_m. Otherwise it SHALL be 0.
- REQ-016 On a cycle with stall=1: IF/ID (instr_d, pc8_d) SHALL hold; ID/EX SHALL load NOP_WORD, pc8 0, dst 0 and tnew 0; EX/MEM and MEM/WB SHALL advance normally.
- REQ-017 On a cycle with stall=0: each register SHALL load the value of its upstream stage; IF/ID SHALL load instr_f and pc_f+8 (32-bit wrap).
- REQ-018 When stall and flush_d are high together, stall SHALL win: IF/ID holds and flush_d SHALL be ignored that cycle.
- REQ-019 stall_cnt SHALL increment by 1 on each clk edge with stall=1 and saturate at 16'hFFFF.
- REQ-020 Latency: a word SHALL appear on instr_d one edge after it is presented on instr_f (without stall), and on instr_w three edges after that.
- REQ-021 Because tnew never exceeds 2 and drops by 1 per advance, a single load-use SHALL produce at most two consecutive stall cycles (beq/jr after lw). No other path SHALL stall longer.

Reset
- REQ-022 While reset=1: all instr_* SHALL equal NOP_WORD, all pc8_* SHALL be 0, all dst and tnew fields SHALL be 0, and stall_cnt SHALL be 0. This SHALL take effect immediately, without waiting for clk.
- REQ-023 stall SHALL be 0 during reset and on the first edge after release.
- REQ-024 When reset asserts mid-stall, all in-flight state SHALL be discarded. After release, fetch SHALL resume from whatever instr_f/pc_f presents.

Verification
- REQ-025 Present lw $1,0($0) then addu $2,$1,$1 -> stall=1 for exactly 1 cycle; instr_e = NOP for 1 cycle; stall_cnt=1.
- REQ-026 Present lw $1 then beq $1,$0 -> stall=1 for exactly 2 cycles, then beq advances; stall_cnt=2.
- REQ-027 Present ori $3,$0,5 then jr $3 -> 1 stall cycle; ori $3 then addu $4,$3,$3 -> 0 stall cycles.
- REQ-028 Present lw $0,0($0) then addu $2,$0,$0 -> 0 stall cycles (register 0 exempt). Present lw $1 then sw $1,0($2) -> 0 stall cycles (rt Tuse=2).
- REQ-029 Assert flush_d with no stall -> instr_d = 0 next cycle, pc8_d = 0; assert flush_d during a load-use stall -> instr_d holds.
- REQ-030 Assert reset asynchronously between edges during a stall -> all outputs reach reset values before the next edge; stall_cnt=0.

Source files
------------

// File: rtl/instr_pipeline.sv
// +----------------------------------------------------------------------+
// | instr_pipeline: five-stage instruction/PC+8 carrier with Tuse/Tnew   |
// | load-use stall detection and a saturating stall counter.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module instr_pipeline #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic        flush_d,
  output logic [31:0] instr_d,
  output logic [31:0] instr_e,
  output logic [31:0] instr_m,
  output logic [31:0] instr_w,
  output logic [31:0] pc8_d,
  output logic [31:0] pc8_e,
  output logic [31:0] pc8_m,
  output logic [31:0] pc8_w,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  logic [31:0] instr_d_q, instr_d_d, pc8_d_q, pc8_d_d;
  logic [31:0] instr_e_q, instr_e_d, pc8_e_q, pc8_e_d;
  logic [4:0]  dst_e_q, dst_e_d;
  logic [1:0]  tnew_e_q, tnew_e_d;
  logic [31:0] instr_m_q, instr_m_d, pc8_m_q, pc8_m_d;
  logic [4:0]  dst_m_q, dst_m_d;
  logic [1:0]  tnew_m_q, tnew_m_d;
  logic [31:0] instr_w_q, instr_w_d, pc8_w_q, pc8_w_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic       rs_use, rt_use;
  logic [1:0] rs_tuse, rt_tuse;
  logic [4:0] dst_dec;
  logic [1:0] tnew_dec;
  logic       stall_rs, stall_rt;

  assign op   = instr_d_q[31:26];
  assign func = instr_d_q[5:0];
  assign rs   = instr_d_q[25:21];
  assign rt   = instr_d_q[20:16];
  assign rd   = instr_d_q[15:11];

  // Decode of the D-stage word: which sources it reads and when, and what it will write.
  always_comb begin
    rs_use   = 1'b0;
    rt_use   = 1'b0;
    rs_tuse  = 2'd0;
    rt_tuse  = 2'd0;
    dst_dec  = 5'd0;
    tnew_dec = 2'd0;
    case (op)
      6'b000000: begin
        case (func)
          6'b100001, 6'b100011: begin
            rs_use   = 1'b1;
            rs_tuse  = 2'd1;
            rt_use   = 1'b1;
            rt_tuse  = 2'd1;
            dst_dec  = rd;
            tnew_dec = 2'd1;
          end
          6'b001000: begin
            rs_use  = 1'b1;
            rs_tuse = 2'd0;
          end
          default: ;
        endcase
      end
      6'b001101: begin
        rs_use   = 1'b1;
        rs_tuse  = 2'd1;
        dst_dec  = rt;
        tnew_dec = 2'd1;
      end
      6'b100011: begin
        rs_use   = 1'b1;
        rs_tuse  = 2'd1;
        dst_dec  = rt;
        tnew_dec = 2'd2;
      end
      6'b101011: begin
        rs_use  = 1'b1;
        rs_tuse = 2'd1;
        rt_use  = 1'b1;
        rt_tuse = 2'd2;
      end
      6'b000100: begin
        rs_use  = 1'b1;
        rs_tuse = 2'd0;
        rt_use  = 1'b1;
        rt_tuse = 2'd0;
      end
      6'b001111: begin
        dst_dec  = rt;
        tnew_dec = 2'd1;
      end
      6'b000011: begin
        dst_dec  = 5'd31;
        tnew_dec = 2'd0;
      end
      default: ;
    endcase
  end

  // W needs no dst/tnew: tnew has always decayed to 0 by the time a word reaches W.
  assign stall_rs = rs_use && (rs != 5'd0) &&
                    (((rs == dst_e_q) && (rs_tuse < tnew_e_q)) ||
                     ((rs == dst_m_q) && (rs_tuse < tnew_m_q)));
  assign stall_rt = rt_use && (rt != 5'd0) &&
                    (((rt == dst_e_q) && (rt_tuse < tnew_e_q)) ||
                     ((rt == dst_m_q) && (rt_tuse < tnew_m_q)));
  assign stall    = stall_rs || stall_rt;

  always_comb begin
    instr_d_d   = instr_d_q;
    pc8_d_d     = pc8_d_q;
    instr_e_d   = NOP_WORD;
    pc8_e_d     = 32'd0;
    dst_e_d     = 5'd0;
    tnew_e_d    = 2'd0;
    instr_m_d   = instr_e_q;
    pc8_m_d     = pc8_e_q;
    dst_m_d     = dst_e_q;
    tnew_m_d    = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
    instr_w_d   = instr_m_q;
    pc8_w_d     = pc8_m_q;
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      instr_e_d = instr_d_q;
      pc8_e_d   = pc8_d_q;
      dst_e_d   = dst_dec;
      tnew_e_d  = tnew_dec;
      if (flush_d) begin
        instr_d_d = NOP_WORD;
        pc8_d_d   = 32'd0;
      end else begin
        instr_d_d = instr_f;
        pc8_d_d   = pc_f + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d_q   <= NOP_WORD;
      pc8_d_q     <= 32'd0;
      instr_e_q   <= NOP_WORD;
      pc8_e_q     <= 32'd0;
      dst_e_q     <= 5'd0;
      tnew_e_q    <= 2'd0;
      instr_m_q   <= NOP_WORD;
      pc8_m_q     <= 32'd0;
      dst_m_q     <= 5'd0;
      tnew_m_q    <= 2'd0;
      instr_w_q   <= NOP_WORD;
      pc8_w_q     <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      instr_d_q   <= instr_d_d;
      pc8_d_q     <= pc8_d_d;
      instr_e_q   <= instr_e_d;
      pc8_e_q     <= pc8_e_d;
      dst_e_q     <= dst_e_d;
      tnew_e_q    <= tnew_e_d;
      instr_m_q   <= instr_m_d;
      pc8_m_q     <= pc8_m_d;
      dst_m_q     <= dst_m_d;
      tnew_m_q    <= tnew_m_d;
      instr_w_q   <= instr_w_d;
      pc8_w_q     <= pc8_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_d   = instr_d_q;
  assign instr_e   = instr_e_q;
  assign instr_m   = instr_m_q;
  assign instr_w   = instr_w_q;
  assign pc8_d     = pc8_d_q;
  assign pc8_e     = pc8_e_q;
  assign pc8_m     = pc8_m_q;
  assign pc8_w     = pc8_w_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_pipeline.sv
// +----------------------------------------------------------------------+
// | tb_instr_pipeline: directed and random stimulus against a reference  |
// | model of the instr_pipeline hazard and stage-advance rules.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_pipeline;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          INF = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_d = 1'b0;
  logic [31:0] instr_f = 32'd0;
  logic [31:0] pc_f = 32'd0;
  logic [31:0] instr_d, instr_e, instr_m, instr_w;
  logic [31:0] pc8_d, pc8_e, pc8_m, pc8_w;
  logic        stall;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  instr_pipeline #(.NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f), .flush_d(flush_d),
    .instr_d(instr_d), .instr_e(instr_e), .instr_m(instr_m), .instr_w(instr_w),
    .pc8_d(pc8_d), .pc8_e(pc8_e), .pc8_m(pc8_m), .pc8_w(pc8_w),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] e_addu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'b000000, s, t, d, 5'd0, 6'b100001};
  endfunction
  function automatic logic [31:0] e_subu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'b000000, s, t, d, 5'd0, 6'b100011};
  endfunction
  function automatic logic [31:0] e_ori(input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
    return {6'b001101, s, t, imm};
  endfunction
  function automatic logic [31:0] e_lw(input logic [4:0] t, input logic [4:0] b);
    return {6'b100011, b, t, 16'h0000};
  endfunction
  function automatic logic [31:0] e_sw(input logic [4:0] t, input logic [4:0] b);
    return {6'b101011, b, t, 16'h0000};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] s, input logic [4:0] t);
    return {6'b000100, s, t, 16'h0001};
  endfunction
  function automatic logic [31:0] e_lui(input logic [4:0] t);
    return {6'b001111, 5'd0, t, 16'h1234};
  endfunction
  function automatic logic [31:0] e_jr(input logic [4:0] s);
    return {6'b000000, s, 15'd0, 6'b001000};
  endfunction

  // Reference model: mnemonic lookup, then a table of dst/Tnew/Tuse per mnemonic.
  typedef struct {
    int dst;
    int tnew;
    int tuse_rs;
    int tuse_rt;
  } dec_t;

  function automatic string mnem(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00 && fn == 6'h21) return "addu";
    if (op == 6'h00 && fn == 6'h23) return "subu";
    if (op == 6'h00 && fn == 6'h08) return "jr";
    if (op == 6'h0d) return "ori";
    if (op == 6'h23) return "lw";
    if (op == 6'h2b) return "sw";
    if (op == 6'h04) return "beq";
    if (op == 6'h0f) return "lui";
    if (op == 6'h02) return "j";
    if (op == 6'h03) return "jal";
    return "other";
  endfunction

  function automatic dec_t decode(input logic [31:0] w);
    dec_t  d;
    string m;
    m = mnem(w);
    d.dst = 0; d.tnew = 0; d.tuse_rs = INF; d.tuse_rt = INF;
    if (m == "addu" || m == "subu") begin
      d.dst = int'(w[15:11]); d.tnew = 1; d.tuse_rs = 1; d.tuse_rt = 1;
    end else if (m == "ori" || m == "lui" || m == "lw") begin
      d.dst = int'(w[20:16]);
      d.tnew = (m == "lw") ? 2 : 1;
      if (m != "lui") d.tuse_rs = 1;
    end else if (m == "sw") begin
      d.tuse_rs = 1; d.tuse_rt = 2;
    end else if (m == "beq") begin
      d.tuse_rs = 0; d.tuse_rt = 0;
    end else if (m == "jr") begin
      d.tuse_rs = 0;
    end else if (m == "jal") begin
      d.dst = 31; d.tnew = 0;
    end
    return d;
  endfunction

  // Index 0=D, 1=E, 2=M, 3=W; Tnew in a stage is the entry Tnew minus its age past E.
  logic [31:0] m_instr[4];
  logic [31:0] m_pc8[4];
  int          m_dst[4];
  int          m_tnew0[4];
  int          m_cnt;

  function automatic bit model_stall();
    dec_t d;
    int   rs, rt, tn;
    bit   st;
    d  = decode(m_instr[0]);
    rs = int'(m_instr[0][25:21]);
    rt = int'(m_instr[0][20:16]);
    st = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tn = m_tnew0[k] - (k - 1);
      if (tn < 0) tn = 0;
      if (rs != 0 && rs == m_dst[k] && d.tuse_rs < tn) st = 1'b1;
      if (rt != 0 && rt == m_dst[k] && d.tuse_rt < tn) st = 1'b1;
    end
    return st;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_instr[k] = NOP; m_pc8[k] = 32'd0; m_dst[k] = 0; m_tnew0[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic [31:0] ins, input logic [31:0] pc, input logic fl);
    bit   st;
    dec_t d;
    st = model_stall();
    d  = decode(m_instr[0]);
    for (int k = 3; k >= 2; k--) begin
      m_instr[k] = m_instr[k-1]; m_pc8[k] = m_pc8[k-1];
      m_dst[k] = m_dst[k-1]; m_tnew0[k] = m_tnew0[k-1];
    end
    if (st) begin
      m_instr[1] = NOP; m_pc8[1] = 32'd0; m_dst[1] = 0; m_tnew0[1] = 0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_instr[1] = m_instr[0]; m_pc8[1] = m_pc8[0]; m_dst[1] = d.dst; m_tnew0[1] = d.tnew;
      m_instr[0] = fl ? NOP : ins;
      m_pc8[0]   = fl ? 32'd0 : pc + 32'd8;
    end
  endtask

  task automatic check_outputs();
    check("instr_d", instr_d, m_instr[0]);
    check("instr_e", instr_e, m_instr[1]);
    check("instr_m", instr_m, m_instr[2]);
    check("instr_w", instr_w, m_instr[3]);
    check("pc8_d", pc8_d, m_pc8[0]);
    check("pc8_e", pc8_e, m_pc8[1]);
    check("pc8_m", pc8_m, m_pc8[2]);
    check("pc8_w", pc8_w, m_pc8[3]);
    check("stall_cnt", {16'd0, stall_cnt}, 32'(m_cnt));
    check("stall", {31'd0, stall}, 32'(model_stall()));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl);
    instr_f = ins; pc_f = pc; flush_d = fl;
    #1;
    check("stall_pre", {31'd0, stall}, 32'(model_stall()));
    @(posedge clk);
    model_edge(ins, pc, fl);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Reset is raised between edges and must take effect before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pair(input string tag, input logic [31:0] w0, input logic [31:0] w1, input int exp_cnt);
    do_reset();
    step(w0, 32'h0000_1000, 1'b0);
    step(w1, 32'h0000_1004, 1'b0);
    for (int i = 0; i < 4; i++) step(NOP, 32'h0000_1008 + 32'(4 * i), 1'b0);
    check(tag, {16'd0, stall_cnt}, 32'(exp_cnt));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0: return e_addu(a, b, c);
      1: return e_subu(a, b, c);
      2: return e_ori(a, b, 16'($urandom));
      3: return e_lw(a, b);
      4: return e_sw(a, b);
      5: return e_beq(a, b);
      6: return e_lui(a);
      7: return {6'b000010, 26'($urandom)};
      8: return {6'b000011, 26'($urandom)};
      9: return e_jr(a);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] held;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    pair("lw_addu_cnt", e_lw(5'd1, 5'd0), e_addu(5'd2, 5'd1, 5'd1), 1);
    pair("lw_beq_cnt", e_lw(5'd1, 5'd0), e_beq(5'd1, 5'd0), 2);
    pair("ori_jr_cnt", e_ori(5'd3, 5'd0, 16'd5), e_jr(5'd3), 1);
    pair("ori_addu_cnt", e_ori(5'd3, 5'd0, 16'd5), e_addu(5'd4, 5'd3, 5'd3), 0);
    pair("lw0_addu_cnt", e_lw(5'd0, 5'd0), e_addu(5'd2, 5'd0, 5'd0), 0);
    pair("lw_sw_cnt", e_lw(5'd1, 5'd0), e_sw(5'd1, 5'd2), 0);

    // Flush without stall, including PC+8 wrap.
    do_reset();
    step(e_addu(5'd2, 5'd3, 5'd4), 32'hFFFF_FFFC, 1'b0);
    check("pc8_wrap", pc8_d, 32'h0000_0004);
    step(e_ori(5'd5, 5'd0, 16'd7), 32'h0000_2000, 1'b1);
    check("flush_instr_d", instr_d, NOP);
    check("flush_pc8_d", pc8_d, 32'd0);

    // Flush during a load-use stall is ignored.
    do_reset();
    held = e_addu(5'd2, 5'd1, 5'd1);
    step(e_lw(5'd1, 5'd0), 32'h0000_3000, 1'b0);
    step(held, 32'h0000_3004, 1'b0);
    step(e_ori(5'd5, 5'd0, 16'd7), 32'h0000_3008, 1'b1);
    check("flush_in_stall_instr_d", instr_d, held);

    // Asynchronous reset in the middle of a two-cycle stall.
    do_reset();
    step(e_lw(5'd1, 5'd0), 32'h0000_4000, 1'b0);
    step(e_beq(5'd1, 5'd0), 32'h0000_4004, 1'b0);
    step(NOP, 32'h0000_4008, 1'b0);
    check("stall_before_reset", {31'd0, stall}, 32'd1);
    do_reset();
    check("cnt_after_reset", {16'd0, stall_cnt}, 32'd0);
    step(e_ori(5'd6, 5'd0, 16'd1), 32'h0000_5000, 1'b0);
    check("resume_fetch", instr_d, e_ori(5'd6, 5'd0, 16'd1));

    // Random traffic with small register numbers to provoke hazards.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      if (i == 300) do_reset();
      step(rand_instr(), pc, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
